// File: rtl/cnn_layer_accel_seq_pkg.sv
// ============================================================================
// cnn_layer_accel_seq_pkg
// Shared types, constants and gray encoding for the weight sequence lookup path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cnn_layer_accel_seq_pkg;

  localparam int C_SEQ_LEN = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Column phase presented to the table: 00, 01, 11, 10 repeating every 4 columns.
  function automatic logic [1:0] f_bin2gray2(input logic [1:0] i_bin);
    return i_bin ^ {1'b0, i_bin[1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cnn_layer_accel_weight_sequence_gen.sv
// ============================================================================
// cnn_layer_accel_weight_sequence_gen
// Walks addr/col/row counters per layer pass and drives the weight sequence table.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cnn_layer_accel_weight_sequence_gen
  import cnn_layer_accel_seq_pkg::*;
#(
  parameter int C_DIM_WIDTH = 10,
  parameter int C_TABLE_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [C_DIM_WIDTH-1:0] cfg_num_cols,
  input  logic [C_DIM_WIDTH-1:0] cfg_num_rows,
  input  logic                   stall,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             gray_code,
  output logic                   sequence_selector,
  output logic [2:0]             seq_data_addr,
  output logic                   seq_valid,
  output logic                   seq_last,
  output logic                   wht_addr_valid
);

  localparam int               C_ADDR_W     = 3;
  localparam logic [C_ADDR_W-1:0] C_ADDR_MAX = C_ADDR_W'(C_SEQ_LEN - 1);
  localparam logic [7:0]       C_DRAIN_LAST = 8'(C_TABLE_LAT - 1);

  seq_state_t             r_state;
  logic [C_ADDR_W-1:0]    r_addr_cnt;
  logic [C_DIM_WIDTH-1:0] r_col_cnt;
  logic [C_DIM_WIDTH-1:0] r_row_cnt;
  logic [C_DIM_WIDTH-1:0] r_col_max;
  logic [C_DIM_WIDTH-1:0] r_row_max;
  logic [7:0]             r_drain_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic [1:0]             r_gray;
  logic                   r_sel;
  logic [C_ADDR_W-1:0]    r_addr_out;
  logic                   r_seq_valid;
  logic                   r_seq_last;
  logic [C_TABLE_LAT-1:0] r_vld_pipe;

  logic w_addr_wrap;
  logic w_col_wrap;
  logic w_row_wrap;
  logic w_cfg_zero;
  logic w_start_ok;

  assign w_addr_wrap = (r_addr_cnt == C_ADDR_MAX);
  assign w_col_wrap  = (r_col_cnt == r_col_max);
  assign w_row_wrap  = (r_row_cnt == r_row_max);
  assign w_cfg_zero  = (cfg_num_cols == '0) || (cfg_num_rows == '0);
  // busy lags the FSM by a cycle, so gating on it also rejects start in the done cycle.
  assign w_start_ok  = start && (r_state == ST_IDLE) && !r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr_cnt  <= '0;
      r_col_cnt   <= '0;
      r_row_cnt   <= '0;
      r_col_max   <= '0;
      r_row_max   <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_gray      <= '0;
      r_sel       <= 1'b0;
      r_addr_out  <= '0;
      r_seq_valid <= 1'b0;
      r_seq_last  <= 1'b0;
    end else begin
      r_busy      <= (r_state != ST_IDLE);
      r_done      <= (r_state == ST_DONE);
      r_seq_valid <= 1'b0;
      r_seq_last  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_col_max  <= cfg_num_cols - 1'b1;
            r_row_max  <= cfg_num_rows - 1'b1;
            r_addr_cnt <= '0;
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
            r_state    <= w_cfg_zero ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            r_seq_valid <= 1'b1;
            r_seq_last  <= w_addr_wrap && w_col_wrap && w_row_wrap;
            r_addr_out  <= r_addr_cnt;
            r_gray      <= f_bin2gray2(r_col_cnt[1:0]);
            r_sel       <= ~r_row_cnt[0];
            if (!w_addr_wrap) begin
              r_addr_cnt <= r_addr_cnt + 1'b1;
            end else begin
              r_addr_cnt <= '0;
              if (!w_col_wrap) begin
                r_col_cnt <= r_col_cnt + 1'b1;
              end else begin
                r_col_cnt <= '0;
                if (!w_row_wrap) begin
                  r_row_cnt <= r_row_cnt + 1'b1;
                end else begin
                  r_row_cnt   <= '0;
                  r_drain_cnt <= '0;
                  r_state     <= ST_DRAIN;
                end
              end
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == C_DRAIN_LAST) begin
            r_state <= ST_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Matches the table's read latency so wht_addr_valid lines up with wht_data_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= r_seq_valid;
      for (int i = 1; i < C_TABLE_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
      end
    end
  end

  assign busy              = r_busy;
  assign done              = r_done;
  assign gray_code         = r_gray;
  assign sequence_selector = r_sel;
  assign seq_data_addr     = r_addr_out;
  assign seq_valid         = r_seq_valid;
  assign seq_last          = r_seq_last;
  assign wht_addr_valid    = r_vld_pipe[C_TABLE_LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_cnn_layer_accel_weight_sequence_gen.sv
// ============================================================================
// tb_cnn_layer_accel_weight_sequence_gen
// Directed and randomized passes checked against a list-based lookup model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cnn_layer_accel_weight_sequence_gen;

  localparam int SEQ = 5;

  typedef struct {
    int addr;
    int gray;
    int sel;
    bit last;
  } lk_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] cfg_num_cols = '0;
  logic [9:0] cfg_num_rows = '0;
  logic       stall = 1'b0;
  logic       busy, done, sequence_selector, seq_valid, seq_last, wht_addr_valid;
  logic [1:0] gray_code;
  logic [2:0] seq_data_addr;

  int checks = 0;
  int errors = 0;
  int gtab[4] = '{0, 1, 3, 2};

  cnn_layer_accel_weight_sequence_gen dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .cfg_num_cols      (cfg_num_cols),
    .cfg_num_rows      (cfg_num_rows),
    .stall             (stall),
    .busy              (busy),
    .done              (done),
    .gray_code         (gray_code),
    .sequence_selector (sequence_selector),
    .seq_data_addr     (seq_data_addr),
    .seq_valid         (seq_valid),
    .seq_last          (seq_last),
    .wht_addr_valid    (wht_addr_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " gray"}, gray_code, 0);
    chk({tag, " sel"}, sequence_selector, 0);
    chk({tag, " addr"}, seq_data_addr, 0);
    chk({tag, " valid"}, seq_valid, 0);
    chk({tag, " last"}, seq_last, 0);
    chk({tag, " wvalid"}, wht_addr_valid, 0);
  endtask

  // mode: 0 = no stall, 1 = random stall, 2 = 4-cycle stall after 7th lookup
  task automatic run_pass(input int cols, input int rows, input int mode, input bit extra,
                          input string nm);
    lk_t q[$];
    int  total, issued, cyc, done_cyc, stall_left, budget;
    bit  exp_issue, prev_valid;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        for (int a = 0; a < SEQ; a++)
          q.push_back('{a, gtab[c % 4], (r % 2 == 0) ? 1 : 0,
                        (r == rows - 1) && (c == cols - 1) && (a == SEQ - 1)});
    total    = q.size();
    done_cyc = (total == 0) ? 2 : -1;
    budget   = total * 3 + 50;
    cfg_num_cols = 10'(cols);
    cfg_num_rows = 10'(rows);
    stall = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; issued = 0; prev_valid = 0; stall_left = 0;
    chk({nm, " c1 valid"}, seq_valid, 0);
    chk({nm, " c1 busy"}, busy, 0);
    while (done_cyc < 0 || cyc <= done_cyc) begin
      if (mode == 1)      stall = ($urandom_range(0, 99) < 30);
      else if (mode == 2) stall = (stall_left > 0);
      else                stall = 1'b0;
      start = 1'b0;
      if (extra) begin
        start = 1'($urandom_range(0, 1));
        cfg_num_cols = 10'($urandom_range(0, 7));
        cfg_num_rows = 10'($urandom_range(0, 7));
        if (cyc == done_cyc) start = 1'b1;
      end
      exp_issue = (issued < total) && !stall;
      @(posedge clk); #1;
      cyc++;
      if (stall_left > 0) stall_left--;
      chk($sformatf("%s seq_valid c%0d", nm, cyc), seq_valid, exp_issue);
      chk($sformatf("%s wht_addr_valid c%0d", nm, cyc), wht_addr_valid, prev_valid);
      if (exp_issue) begin
        chk($sformatf("%s addr #%0d", nm, issued), seq_data_addr, q[issued].addr);
        chk($sformatf("%s gray #%0d", nm, issued), gray_code, q[issued].gray);
        chk($sformatf("%s sel #%0d", nm, issued), sequence_selector, q[issued].sel);
        chk($sformatf("%s last #%0d", nm, issued), seq_last, q[issued].last);
        issued++;
        if (issued == total) done_cyc = cyc + 2;
        if (mode == 2 && issued == 7) stall_left = 4;
      end else if (issued > 0 && issued < total) begin
        chk($sformatf("%s held addr c%0d", nm, cyc), seq_data_addr, q[issued-1].addr);
        chk($sformatf("%s held gray c%0d", nm, cyc), gray_code, q[issued-1].gray);
        chk($sformatf("%s held sel c%0d", nm, cyc), sequence_selector, q[issued-1].sel);
        chk($sformatf("%s held last c%0d", nm, cyc), seq_last, 0);
      end
      chk($sformatf("%s busy c%0d", nm, cyc), busy,
          (cyc >= 2) && (done_cyc < 0 || cyc <= done_cyc));
      chk($sformatf("%s done c%0d", nm, cyc), done, (cyc == done_cyc));
      prev_valid = exp_issue;
      if (cyc > budget) begin
        chk({nm, " timeout"}, 1, 0);
        break;
      end
    end
    chk({nm, " lookup count"}, issued, total);
    start = 1'b0;
    stall = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk({nm, " post busy"}, busy, 0);
      chk({nm, " post valid"}, seq_valid, 0);
      chk({nm, " post done"}, done, 0);
    end
  endtask

  initial begin
    int n, t;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("idle");

    run_pass(2, 1, 0, 1'b0, "c2r1");
    run_pass(5, 2, 0, 1'b0, "c5r2");
    run_pass(3, 1, 2, 1'b0, "stall7");
    run_pass(0, 3, 0, 1'b1, "cols0");
    run_pass(4, 0, 0, 1'b0, "rows0");
    run_pass(1, 1, 0, 1'b0, "c1r1");

    // abort a pass at row 0, col 1
    cfg_num_cols = 10'd4;
    cfg_num_rows = 10'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; t = 0;
    while (n < 7 && t < 100) begin
      @(posedge clk); #1;
      t++;
      if (seq_valid) n++;
    end
    chk("abort reached lookup 7", n, 7);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    repeat (2) begin
      @(posedge clk); #1;
      chk_all_zero("reset held");
    end
    #3 rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("no done after abort", done, 0);
      chk("no busy after abort", busy, 0);
    end
    run_pass(3, 2, 0, 1'b0, "after_abort");

    run_pass(1023, 1, 0, 1'b0, "cols1023");
    for (int k = 0; k < 6; k++) begin
      run_pass($urandom_range(1, 6), $urandom_range(1, 4), 1, 1'b1, $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
